// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: copies a block of instruction words from backing memory
// into the instruction cache, one outstanding read at a time, and muxes the
// single cache address port between the fill engine and instruction fetch.
// Optional feature macro: ICACHE_FILL_ABORT_EN adds abort_i and a DRAIN state
// that swallows an in-flight memory response after an abort.
module icache_fill_ctrl #(
  parameter int addr_wid       = 64,
  parameter int instr_wid      = 32,
  parameter int length         = 100,
  parameter int bytes_per_word = instr_wid >> 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [addr_wid-1:0]            base_addr_i,
  input  logic [$clog2(length+1)-1:0]    count_i,
  output logic                           mem_req_o,
  output logic [addr_wid-1:0]            mem_addr_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [instr_wid-1:0]           mem_rdata_i,
  output logic                           wr_instr_en_o,
  output logic [instr_wid-1:0]           wr_instr_o,
  output logic [addr_wid-1:0]            cache_addr_o,
  input  logic [addr_wid-1:0]            fetch_addr_i,
  output logic                           fetch_stall_o,
  output logic                           busy_o,
  output logic                           done_o,
`ifdef ICACHE_FILL_ABORT_EN
  input  logic                           abort_i,
`endif
  output logic                           err_o
);

  localparam int cnt_wid = $clog2(length + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
`ifdef ICACHE_FILL_ABORT_EN
    DRAIN,
`endif
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [addr_wid-1:0]  base_q, base_d;
  logic [cnt_wid-1:0]   count_q, count_d;
  logic [cnt_wid-1:0]   idx_q, idx_d;
  logic [instr_wid-1:0] data_q, data_d;
  logic                 err_q, err_d;

  logic [cnt_wid-1:0]   idxInc;
  logic [addr_wid-1:0]  fillOffset;
  logic                 busy;

  assign idxInc     = idx_q + cnt_wid'(1);
  assign fillOffset = addr_wid'(idx_q) * addr_wid'(bytes_per_word);

  // State and datapath registers; reset drops any fill in progress at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: sequence REQ -> WAIT -> WRITE once per word.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i == '0) begin
            state_d = DONE;
          end else if (count_i > cnt_wid'(length)) begin
            err_d = 1'b1;
          end else begin
            base_d  = base_addr_i;
            count_d = count_i;
            idx_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
`ifdef ICACHE_FILL_ABORT_EN
        // A grant in the abort cycle leaves a read in flight, so drain it.
        if (abort_i) state_d = mem_gnt_i ? DRAIN : IDLE;
        else
`endif
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
`ifdef ICACHE_FILL_ABORT_EN
        // A response arriving with the abort is already consumed here.
        if (abort_i) state_d = mem_rvalid_i ? IDLE : DRAIN;
        else
`endif
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d   = idxInc;
        state_d = (idxInc == count_q) ? DONE : REQ;
`ifdef ICACHE_FILL_ABORT_EN
        if (abort_i) state_d = IDLE;
`endif
      end
`ifdef ICACHE_FILL_ABORT_EN
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: memory request, cache write strobe and port ownership.
  always_comb begin
    busy          = (state_q != IDLE);
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    wr_instr_en_o = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q + fillOffset;
      end
      WRITE: wr_instr_en_o = 1'b1;
      DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o        = busy;
  assign fetch_stall_o = busy;
  assign cache_addr_o  = busy ? fillOffset : fetch_addr_i;
  assign wr_instr_o    = data_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Testbench for icache_fill_ctrl. A memory responder with random grant and
// response delays drives the fill; expected reads, writes and done timing
// come from the per-word rules: word i is read from base+4i and written to
// cache address 4i, and a zero-wait fill of N words ends on cycle 3N+1.
module tb_icache_fill_ctrl;

  localparam int AW  = 64;
  localparam int IW  = 32;
  localparam int LEN = 100;
  localparam int CW  = $clog2(LEN + 1);
  localparam int BPW = IW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [CW-1:0] count = '0;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memGnt = 1'b0;
  logic          memRvalid = 1'b0;
  logic [IW-1:0] memRdata = '0;
  logic          wrEn;
  logic [IW-1:0] wrInstr;
  logic [AW-1:0] cacheAddr;
  logic [AW-1:0] fetchAddr = 64'h0000_0000_0040_0100;
  logic          fetchStall;
  logic          busy;
  logic          done;
  logic          err;
`ifdef ICACHE_FILL_ABORT_EN
  logic          abort = 1'b0;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  icache_fill_ctrl #(
    .addr_wid(AW), .instr_wid(IW), .length(LEN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .base_addr_i(baseAddr),
    .count_i(count),
    .mem_req_o(memReq),
    .mem_addr_o(memAddr),
    .mem_gnt_i(memGnt),
    .mem_rvalid_i(memRvalid),
    .mem_rdata_i(memRdata),
    .wr_instr_en_o(wrEn),
    .wr_instr_o(wrInstr),
    .cache_addr_o(cacheAddr),
    .fetch_addr_i(fetchAddr),
    .fetch_stall_o(fetchStall),
    .busy_o(busy),
    .done_o(done),
`ifdef ICACHE_FILL_ABORT_EN
    .abort_i(abort),
`endif
    .err_o(err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one edge; returns at the negedge of the first busy cycle.
  task automatic applyStimulus(input logic [63:0] base, input int cnt);
    baseAddr = base;
    count    = CW'(cnt);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_stall"}, fetchStall, 0);
    checkOutput({tag, "_req"}, memReq, 0);
    checkOutput({tag, "_cache_addr"}, cacheAddr, fetchAddr);
  endtask

  // Run one fill against a memory with grant/response delays in the given
  // ranges, checking every request, every write and the completion pulse.
  task automatic runFill(input logic [63:0] base, input int cnt,
                         input int gntLo, input int gntHi,
                         input int rvLo, input int rvHi, input bit directed);
    logic [IW-1:0] expData[$];
    int  reads = 0;
    int  writes = 0;
    int  cycle = 1;
    int  doneCycle = -1;
    int  gntCd;
    int  rvCd = 0;
    bit  outstanding = 1'b0;
    bit  finished = 1'b0;
    for (int i = 0; i < cnt; i++)
      expData.push_back(directed ? IW'(32'hA0 + i) : IW'($urandom));
    gntCd = int'($urandom_range(gntHi, gntLo));
    applyStimulus(base, cnt);
    while (!finished && cycle < 4000) begin
      checkOutput("fill_stall", fetchStall, 1);
      if (wrEn) begin
        if (writes < cnt) begin
          checkOutput("write_addr", cacheAddr, 64'(writes) * 64'(BPW));
          checkOutput("write_data", wrInstr, expData[writes]);
        end else begin
          checkOutput("extra_write", writes + 1, cnt);
        end
        writes++;
        outstanding = 1'b0;
        memRvalid   = 1'b0;
      end
      if (done) begin
        doneCycle = cycle;
        finished  = 1'b1;
      end else begin
        if (outstanding && !memRvalid) begin
          if (rvCd == 0) begin
            memRvalid = 1'b1;
            memRdata  = (reads <= cnt) ? expData[reads-1] : '0;
          end else begin
            rvCd--;
          end
        end
        memGnt = 1'b0;
        if (memReq) begin
          checkOutput("one_outstanding", outstanding, 0);
          checkOutput("req_addr", memAddr, base + 64'(reads) * 64'(BPW));
          if (gntCd == 0) begin
            memGnt      = 1'b1;
            reads++;
            outstanding = 1'b1;
            rvCd        = int'($urandom_range(rvHi, rvLo));
            gntCd       = int'($urandom_range(gntHi, gntLo));
          end else begin
            gntCd--;
          end
        end
      end
      @(negedge clk);
      cycle++;
    end
    memGnt    = 1'b0;
    memRvalid = 1'b0;
    checkOutput("fill_finished", finished, 1);
    checkOutput("read_count", reads, cnt);
    checkOutput("write_count", writes, cnt);
    if (gntHi == 0 && rvHi == 0)
      checkOutput("done_cycle", doneCycle, 3 * cnt + 1);
    checkIdle("after_fill");
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_req", memReq, 0);
    checkOutput("rst_mem_addr", memAddr, 0);
    checkOutput("rst_wr_en", wrEn, 0);
    checkOutput("rst_wr_instr", wrInstr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkIdle("rst");
    rst = 1'b0;
    @(negedge clk);

    // Directed normal fill, zero-wait memory, data A0..A3.
    runFill(64'h1000, 4, 0, 0, 0, 0, 1'b1);

    // Zero count: immediate done, no memory traffic.
    applyStimulus(64'h2000, 0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_req", memReq, 0);
    checkOutput("zero_wr", wrEn, 0);
    checkOutput("zero_err", err, 0);
    @(negedge clk);
    checkOutput("zero_done_end", done, 0);
    checkOutput("zero_wr_end", wrEn, 0);
    checkIdle("zero");

    // Oversize count: one err pulse, stays idle.
    applyStimulus(64'h3000, LEN + 1);
    checkOutput("over_err", err, 1);
    checkOutput("over_done", done, 0);
    checkIdle("over");
    @(negedge clk);
    checkOutput("over_err_end", err, 0);
    checkIdle("over_end");

    // Backpressure: grant after 3 cycles, response after 2.
    runFill(64'h4000, 2, 3, 3, 2, 2, 1'b0);

    // Boundaries: maximum count and an address range that wraps.
    runFill(64'h8000, LEN, 0, 0, 0, 0, 1'b0);
    runFill(64'hFFFF_FFFF_FFFF_FFF8, 4, 0, 0, 0, 0, 1'b0);

    // Randomized fills with random delays and fetch addresses.
    for (int n = 0; n < 6; n++) begin
      fetchAddr = {$urandom, $urandom};
      runFill({$urandom, $urandom}, int'($urandom_range(8, 1)), 0, 3, 0, 3, 1'b0);
    end

    // Reset in WAIT of the second word, then a stray response.
    applyStimulus(64'h5000, 3);
    memGnt = 1'b1;
    @(negedge clk);
    memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("mid_first_write", wrEn, 1);
    memRvalid = 1'b0;
    @(negedge clk);
    checkOutput("mid_second_req", memReq, 1);
    memGnt = 1'b1;
    @(negedge clk);
    memGnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_req", memReq, 0);
    checkOutput("mid_rst_mem_addr", memAddr, 0);
    checkOutput("mid_rst_wr", wrEn, 0);
    checkOutput("mid_rst_wr_instr", wrInstr, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_stall", fetchStall, 0);
    @(negedge clk);
    rst = 1'b0;
    memRvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stray_wr", wrEn, 0);
      checkIdle("stray");
    end
    memRvalid = 1'b0;

`ifdef ICACHE_FILL_ABORT_EN
    // Abort in WAIT: DRAIN swallows the response, no write, no done.
    applyStimulus(64'h6000, 2);
    memGnt = 1'b1;
    @(negedge clk);
    memGnt = 1'b0;
    abort  = 1'b1;
    @(negedge clk);
    abort  = 1'b0;
    checkOutput("abort_drain_busy", busy, 1);
    checkOutput("abort_drain_wr", wrEn, 0);
    checkOutput("abort_drain_req", memReq, 0);
    memRvalid = 1'b1; memRdata = 32'h1234_5678;
    @(negedge clk);
    memRvalid = 1'b0;
    checkOutput("abort_wr", wrEn, 0);
    checkOutput("abort_done", done, 0);
    checkIdle("abort");
    @(negedge clk);
    checkOutput("abort_wr_late", wrEn, 0);
    checkIdle("abort_late");
`endif

    // A normal fill still works after everything above.
    runFill(64'h7000, 3, 0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Sequencing controller that loads a block of instructions from backing memory into the instruction cache and shares the cache's single address port between the fill engine and instruction fetch. A fill copies `count_i` consecutive words starting at `base_addr_i`, one outstanding memory read at a time. While the fill runs, fetch is stalled and owns no part of the cache port. It sits between the fetch stage, the memory read port and the instruction cache write/lookup ports.

## Interface
Parameters:
- `addr_wid`, 64: address width.
- `instr_wid`, 32: instruction word width.
- `length`, 100: cache depth in words; maximum legal `count_i`.
- `bytes_per_word`, `instr_wid >> 3`: address stride per word.

Ports:
- `clk_i` in 1: single clock; all logic rises on posedge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin fill; sampled only in IDLE.
- `base_addr_i` in addr_wid: memory byte address of word 0; captured with start.
- `count_i` in $clog2(length+1): words to load; captured with start.
- `mem_req_o` out 1: memory read request.
- `mem_addr_o` out addr_wid: memory read byte address.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in instr_wid: read data.
- `wr_instr_en_o` out 1: cache write strobe.
- `wr_instr_o` out instr_wid: cache write data.
- `cache_addr_o` out addr_wid: cache address port (muxed).
- `fetch_addr_i` in addr_wid: fetch lookup address.
- `fetch_stall_o` out 1: fetch must hold.
- `busy_o` out 1: fill in progress.
- `done_o` out 1: one-cycle pulse at fill completion.
- `err_o` out 1: one-cycle pulse on rejected start.
- `abort_i` in 1: present only with `ICACHE_FILL_ABORT_EN`.

## Operation
- States: IDLE, REQ, WAIT, WRITE, DONE, plus DRAIN with the macro.
- IDLE:
  - `start_i=1` and `0 < count_i <= length`: latch base and count, clear index `idx`, go to REQ.
  - `count_i=0`: go to DONE with no memory traffic.
  - `count_i > length`: pulse `err_o` next cycle and stay in IDLE.
- REQ: `mem_req_o=1`, `mem_addr_o = base + idx*bytes_per_word`. Use addr_wid arithmetic; wrap-around modulo 2^addr_wid is allowed. Move to WAIT on `mem_gnt_i`.
- WAIT: hold until `mem_rvalid_i`; register `mem_rdata_i`, go to WRITE.
  - `mem_rvalid_i` in the same cycle as the grant is legal; it is taken in WAIT on the following cycle only if it is still high, so memory must hold rvalid until seen.
- WRITE: `wr_instr_en_o=1` for exactly one cycle with the registered data; `cache_addr_o = idx*bytes_per_word`. Increment `idx`. If `idx+1 == count`, go to DONE; otherwise go to REQ.
- DONE: `done_o=1` for one cycle, go to IDLE.
- Port ownership:
  - `busy_o=1` in every state except IDLE.
  - `fetch_stall_o = busy_o`.
  - `cache_addr_o = fetch_addr_i` in IDLE, else the fill address.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, `idx=0`; all 1-bit outputs 0; `mem_addr_o`, `wr_instr_o` and the registered data are 0.
  - Reset mid-fill abandons the fill immediately. Any in-flight memory response after reset is ignored because the block is in IDLE.
- Per-word latency with zero-wait memory (gnt in REQ, rvalid on the next cycle): REQ, WAIT, WRITE = 3 cycles. A fill of N words takes 3N+1 cycles from the start edge to the `done_o` pulse.
- At most one outstanding read at any time.
- `done_o` and `err_o` never assert in the same cycle.

## Configuration
- `ICACHE_FILL_ABORT_EN` defined:
  - `abort_i` exists.
  - `abort_i=1` in REQ before grant: go to IDLE next cycle; no write and no `done_o`.
  - `abort_i=1` in WAIT: go to DRAIN, which waits for `mem_rvalid_i`, discards the data, then goes to IDLE.
  - `abort_i=1` in WRITE: the current write completes, then the block goes to IDLE.
  - Abort has no effect in IDLE or DONE.
- `ICACHE_FILL_ABORT_EN` undefined: no `abort_i` port, no DRAIN state; a fill always runs to completion.

## Test plan
- Normal fill: reset, start with base=0x1000, count=4, zero-wait memory returning 0xA0..0xA3. Required: reads at 0x1000/1004/1008/100C; writes at cache addresses 0/4/8/C; `done_o` on cycle 13; `fetch_stall_o` high throughout.
- Zero count: `count_i=0`. Required: `done_o` pulse, no `mem_req_o`, no write.
- Oversize count: `count_i=101`. Required: `err_o` single pulse, state stays IDLE, no requests.
- Backpressure: `mem_gnt_i` delayed 3 cycles and `rvalid` delayed 2 cycles per word, count=2. Required: `mem_addr_o` stable while requesting; exactly 2 writes; correct data.
- Reset mid-fill: assert `rst_i` in WAIT of word 1. Required: all outputs zero asynchronously; a later stray `rvalid` causes no write.
- Abort (macro on): `abort_i` in WAIT. Required: DRAIN consumes the response, no write, no `done_o`, IDLE afterwards, and `cache_addr_o` follows `fetch_addr_i` again.
